msrv32_dmem_bus_master: RTL and testbench
=========================================

# msrv32_dmem_bus_master

Data-memory access sequencer on the memory side of pipeline register stage 2. It takes the registered load/store request (effective address from the immediate adder, store data from rs2, load size and signedness) and runs a req/ack handshake with the data memory. It generates byte-lane strobes, aligns and extends load data, and holds the pipeline with a stall until the access completes, errors or times out.

## Interface
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without ack before abort (1..255, 8-bit counter)
- clk_in  in  1  clock, all state on rising edge
- reset_in  in  1  reset, synchronous, active-low
- req_valid_in  in  1  load/store request present (registered pipeline output)
- req_write_in  in  1  1 = store, 0 = load
- addr_in  in  32  effective byte address (registered iadder)
- wdata_in  in  32  store data (registered rs2)
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned_in  in  1  1 = zero-extend load, 0 = sign-extend
- dmem_req_out  out  1  bus request
- dmem_we_out  out  1  bus write enable
- dmem_addr_out  out  32  word address, bits [1:0] forced 00
- dmem_wdata_out  out  32  lane-replicated store data
- dmem_wr_mask_out  out  4  byte strobes, bit i = byte lane i
- dmem_ack_in  in  1  bus acknowledge / read data valid
- dmem_rdata_in  in  32  bus read word
- rdata_out  out  32  aligned, extended load result
- done_out  out  1  one-cycle completion pulse
- stall_out  out  1  pipeline hold
- misaligned_out  out  1  one-cycle misaligned-access pulse
- bus_err_out  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, BUSY, RESP. Reset (reset_in=0 at edge) -> IDLE, wait counter 0, all outputs 0, rdata_out 0.
- Misaligned: half with addr_in[0]=1; word (10/11) with addr_in[1:0]!=00. Byte never misaligned.
- IDLE, req_valid_in=1, misaligned: no bus cycle. misaligned_out=1 next cycle. State stays IDLE.
- IDLE, req_valid_in=1, aligned: latch write, size, unsigned and addr[1:0]. Register the bus outputs. Go BUSY with counter cleared.
- Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Loads: mask 0000, we 0, wdata 0.
- BUSY: dmem_req_out=1. Addr/we/mask/wdata held stable.
  - On dmem_ack_in=1: drop req next cycle and go RESP. For loads, capture the result into rdata_out.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT_CYCLES without ack: drop req, pulse bus_err_out, go IDLE, no done_out.
- Load extraction: byte = rdata lane addr[1:0]; half = rdata[31:16] if addr[1] else [15:0]; word = rdata as-is. Sign-extend from bit 7/15 unless load_unsigned latched 1.
- RESP: done_out=1 for exactly one cycle, then IDLE. rdata_out holds until the next completed load; stores and errors leave it unchanged.
- stall_out is combinational:
  - 1 in BUSY.
  - 1 in IDLE when req_valid_in=1 and aligned.
  - 0 in RESP and otherwise.
  - Pipeline advances on the RESP cycle.
- req_valid_in is ignored in BUSY and RESP. dmem_ack_in is ignored outside BUSY.

## Timing
- Accept at edge N (IDLE). dmem_req_out high from N+1.
- Ack sampled high at edge M (M>=N+1). dmem_req_out low and done_out high from M+1, for one cycle. IDLE from M+2.
- Zero-wait memory (ack in the first BUSY cycle): done_out 2 cycles after accept. A new request can be accepted at M+2.
- Misaligned: request sampled at edge N, misaligned_out high in cycle N+1, stall_out never asserted.
- Timeout: with no ack for TIMEOUT_CYCLES BUSY cycles, req drops and bus_err_out pulses on the same edge.
- Reset low during BUSY or RESP: next edge forces IDLE with all outputs 0. No done_out or bus_err_out is produced for the aborted access.
- Ack and timeout at the same edge: ack wins, normal completion.

## Test plan
- Store byte, addr 0x00001003, wdata 0x000000A5, ack after 0 waits -> dmem_addr 0x00001000, mask 1000, wdata 0xA5A5A5A5, we=1, done 2 cycles after accept.
- Load half signed, addr 0x00002002, rdata 0x8001_1234 on ack after 3 waits -> rdata_out 0xFFFF8001, stall high 5 cycles (accept + 4 BUSY) then low on the done cycle.
- Load byte unsigned, addr 0x00002001, rdata 0x0000F000 -> rdata_out 0x000000F0. The same access signed -> 0xFFFFFFF0.
- Word load at addr 0x00003002 -> misaligned_out pulse, dmem_req_out stays 0, done_out stays 0, rdata_out unchanged.
- TIMEOUT_CYCLES=4, store with ack held low -> dmem_req_out high 4 cycles, bus_err_out pulse, IDLE, no done_out. Next request is accepted normally.
- Reset low for one edge during BUSY -> all outputs 0 next cycle, no done_out. Later ack is ignored.

Source files
------------

// File: rtl/msrv32_dmem_bus_master.sv
// Data-memory access sequencer: req/ack handshake, byte-lane strobes,
// load alignment/extension, timeout abort and pipeline stall generation.
module msrv32_dmem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid_in,
  input  logic        req_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wr_mask_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] rdata_out,
  output logic        done_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic             misaligned_c;
  logic             timeout_c;
  logic [3:0]       strb_c;
  logic [31:0]      wrep_c;
  logic [7:0]       lb_c;
  logic [15:0]      lh_c;
  logic [31:0]      load_ext_c;

  // Request decode: alignment, byte strobes and lane-replicated store data
  always_comb begin
    misaligned_c = 1'b0;
    strb_c       = 4'b1111;
    wrep_c       = wdata_in;
    case (load_size_in)
      2'b00: begin
        strb_c = 4'(4'b0001 << addr_in[1:0]);
        wrep_c = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        misaligned_c = addr_in[0];
        strb_c       = 4'(4'b0011 << addr_in[1:0]);
        wrep_c       = {2{wdata_in[15:0]}};
      end
      default: misaligned_c = (addr_in[1:0] != 2'b00);
    endcase
  end

  // Load lane selection and extension using the latched access attributes
  always_comb begin
    case (off_q)
      2'd0:    lb_c = dmem_rdata_in[7:0];
      2'd1:    lb_c = dmem_rdata_in[15:8];
      2'd2:    lb_c = dmem_rdata_in[23:16];
      default: lb_c = dmem_rdata_in[31:24];
    endcase
    lh_c = off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    case (size_q)
      2'b00:   load_ext_c = uns_q ? {24'b0, lb_c} : {{24{lb_c[7]}}, lb_c};
      2'b01:   load_ext_c = uns_q ? {16'b0, lh_c} : {{16{lh_c[15]}}, lh_c};
      default: load_ext_c = dmem_rdata_in;
    endcase
  end

  assign timeout_c = (state_q == BUSY) && !dmem_ack_in && (cnt_q == TMO_LAST);

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; ack takes priority over timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_in && !misaligned_c) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (dmem_ack_in)    state_d = RESP;
        else if (timeout_c) state_d = IDLE;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: bus fields held through BUSY, pulses default low
  always_comb begin
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          if (misaligned_c) begin
            mis_d = 1'b1;
          end else begin
            wr_d    = req_write_in;
            size_d  = load_size_in;
            uns_d   = load_unsigned_in;
            off_d   = addr_in[1:0];
            req_d   = 1'b1;
            we_d    = req_write_in;
            addr_d  = {addr_in[31:2], 2'b00};
            mask_d  = req_write_in ? strb_c : 4'b0000;
            wdata_d = req_write_in ? wrep_c : 32'h0;
          end
        end
      end
      BUSY: begin
        if (dmem_ack_in) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          if (!wr_q) rdata_d = load_ext_c;
        end else if (timeout_c) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  assign stall_out = (state_q == BUSY) ||
                     ((state_q == IDLE) && req_valid_in && !misaligned_c);

  assign dmem_req_out     = req_q;
  assign dmem_we_out      = we_q;
  assign dmem_addr_out    = addr_q;
  assign dmem_wdata_out   = wdata_q;
  assign dmem_wr_mask_out = mask_q;
  assign rdata_out        = rdata_q;
  assign done_out         = done_q;
  assign misaligned_out   = mis_q;
  assign bus_err_out      = err_q;

endmodule

// File: tb/tb_msrv32_dmem_bus_master.sv
// Directed bench for msrv32_dmem_bus_master with a short timeout so the
// abort path and ack-at-timeout priority are both reachable.
module tb_msrv32_dmem_bus_master;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_write_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wr_mask_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic [31:0] rdata_out;
  logic        done_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int errors = 0;
  int checks = 0;

  msrv32_dmem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .req_valid_in     (req_valid_in),
    .req_write_in     (req_write_in),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .dmem_req_out     (dmem_req_out),
    .dmem_we_out      (dmem_we_out),
    .dmem_addr_out    (dmem_addr_out),
    .dmem_wdata_out   (dmem_wdata_out),
    .dmem_wr_mask_out (dmem_wr_mask_out),
    .dmem_ack_in      (dmem_ack_in),
    .dmem_rdata_in    (dmem_rdata_in),
    .rdata_out        (rdata_out),
    .done_out         (done_out),
    .stall_out        (stall_out),
    .misaligned_out   (misaligned_out),
    .bus_err_out      (bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    req_valid_in     = 1'b1;
    req_write_in     = wr;
    addr_in          = a;
    wdata_in         = wd;
    load_size_in     = sz;
    load_unsigned_in = uns;
  endtask

  // Accept a load, ack it after `waits` empty BUSY cycles, check the result
  task automatic load_op(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] rd, input int waits,
                         input logic [31:0] exp);
    issue(1'b0, a, 32'h0, sz, uns);
    tick();
    req_valid_in = 1'b0;
    for (int i = 0; i < waits; i++) tick();
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = rd;
    tick();
    dmem_ack_in   = 1'b0;
    dmem_rdata_in = 32'h0;
    chk({tag, "_done"}, 32'(done_out), 32'h1);
    chk({tag, "_rdata"}, rdata_out, exp);
    tick();
  endtask

  initial begin
    reset_in = 1'b0;
    req_valid_in = 1'b0; req_write_in = 1'b0; addr_in = '0; wdata_in = '0;
    load_size_in = 2'b00; load_unsigned_in = 1'b0;
    dmem_ack_in = 1'b0; dmem_rdata_in = '0;
    tick(); tick();
    chk("rst_req",   32'(dmem_req_out), 32'h0);
    chk("rst_done",  32'(done_out), 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_mask",  32'(dmem_wr_mask_out), 32'h0);
    reset_in = 1'b1;
    tick();

    // Store byte at lane 3, zero-wait ack
    issue(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00, 1'b0);
    #1 chk("sb_stall_acc", 32'(stall_out), 32'h1);
    tick();
    req_valid_in = 1'b0;
    chk("sb_req",   32'(dmem_req_out), 32'h1);
    chk("sb_we",    32'(dmem_we_out), 32'h1);
    chk("sb_addr",  dmem_addr_out, 32'h0000_1000);
    chk("sb_mask",  32'(dmem_wr_mask_out), 32'h8);
    chk("sb_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
    chk("sb_done0", 32'(done_out), 32'h0);
    dmem_ack_in = 1'b1;
    tick();
    dmem_ack_in = 1'b0;
    chk("sb_done",  32'(done_out), 32'h1);
    chk("sb_reqlo", 32'(dmem_req_out), 32'h0);
    chk("sb_stall_resp", 32'(stall_out), 32'h0);
    tick();
    chk("sb_done_pulse", 32'(done_out), 32'h0);

    // Signed half load, 3 waits; ack coincides with the timeout point
    issue(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b0);
    #1 chk("lh_stall_acc", 32'(stall_out), 32'h1);
    tick();
    req_valid_in = 1'b0;
    chk("lh_addr", dmem_addr_out, 32'h0000_2000);
    chk("lh_mask", 32'(dmem_wr_mask_out), 32'h0);
    chk("lh_we",   32'(dmem_we_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("lh_stall_busy", 32'(stall_out), 32'h1);
      chk("lh_req_busy", 32'(dmem_req_out), 32'h1);
      if (i < 3) tick();
    end
    dmem_ack_in = 1'b1;
    dmem_rdata_in = 32'h8001_1234;
    tick();
    dmem_ack_in = 1'b0;
    dmem_rdata_in = 32'h0;
    chk("lh_done",  32'(done_out), 32'h1);
    chk("lh_rdata", rdata_out, 32'hFFFF_8001);
    chk("lh_stall_resp", 32'(stall_out), 32'h0);
    chk("lh_noerr", 32'(bus_err_out), 32'h0);
    tick();
    chk("lh_noerr2", 32'(bus_err_out), 32'h0);

    // Byte loads, lane 1, unsigned then signed
    load_op("lbu", 32'h0000_2001, 2'b00, 1'b1, 32'h0000_F000, 0, 32'h0000_00F0);
    load_op("lb",  32'h0000_2001, 2'b00, 1'b0, 32'h0000_F000, 1, 32'hFFFF_FFF0);
    load_op("lw",  32'h0000_2004, 2'b10, 1'b0, 32'hCAFE_0123, 2, 32'hCAFE_0123);
    load_op("lhu", 32'h0000_2000, 2'b01, 1'b1, 32'h0123_9ABC, 0, 32'h0000_9ABC);
    load_op("lb",  32'h0000_2001, 2'b00, 1'b0, 32'h0000_F000, 0, 32'hFFFF_FFF0);

    // Misaligned word load: pulse only, no bus cycle, no stall
    issue(1'b0, 32'h0000_3002, 32'h0, 2'b10, 1'b0);
    #1 chk("mis_stall", 32'(stall_out), 32'h0);
    tick();
    req_valid_in = 1'b0;
    chk("mis_pulse", 32'(misaligned_out), 32'h1);
    chk("mis_req",   32'(dmem_req_out), 32'h0);
    chk("mis_done",  32'(done_out), 32'h0);
    chk("mis_rdata", rdata_out, 32'hFFFF_FFF0);
    tick();
    chk("mis_pulse_end", 32'(misaligned_out), 32'h0);
    chk("mis_req2", 32'(dmem_req_out), 32'h0);

    // Misaligned half at odd address
    issue(1'b1, 32'h0000_3001, 32'h1111_2222, 2'b01, 1'b0);
    tick();
    req_valid_in = 1'b0;
    chk("mish_pulse", 32'(misaligned_out), 32'h1);
    chk("mish_req",   32'(dmem_req_out), 32'h0);
    tick();

    // Store with no ack: 4 BUSY cycles then timeout
    issue(1'b1, 32'h0000_4000, 32'h1234_5678, 2'b10, 1'b0);
    tick();
    req_valid_in = 1'b0;
    chk("to_mask",  32'(dmem_wr_mask_out), 32'hF);
    chk("to_wdata", dmem_wdata_out, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_busy", 32'(dmem_req_out), 32'h1);
      chk("to_err_low", 32'(bus_err_out), 32'h0);
      tick();
    end
    chk("to_reqlo", 32'(dmem_req_out), 32'h0);
    chk("to_err",   32'(bus_err_out), 32'h1);
    chk("to_nodone", 32'(done_out), 32'h0);
    chk("to_stall", 32'(stall_out), 32'h0);
    tick();
    chk("to_err_pulse", 32'(bus_err_out), 32'h0);
    chk("to_nodone2", 32'(done_out), 32'h0);
    chk("to_rdata", rdata_out, 32'hFFFF_FFF0);

    // Half store at upper half after the abort
    issue(1'b1, 32'h0000_4006, 32'h0000_BEEF, 2'b01, 1'b0);
    tick();
    req_valid_in = 1'b0;
    chk("sh_req",   32'(dmem_req_out), 32'h1);
    chk("sh_addr",  dmem_addr_out, 32'h0000_4004);
    chk("sh_mask",  32'(dmem_wr_mask_out), 32'hC);
    chk("sh_wdata", dmem_wdata_out, 32'hBEEF_BEEF);
    dmem_ack_in = 1'b1;
    dmem_rdata_in = 32'h5555_5555;
    tick();
    dmem_ack_in = 1'b0;
    chk("sh_done",  32'(done_out), 32'h1);
    chk("sh_rdata", rdata_out, 32'hFFFF_FFF0);
    tick();

    // Reset during BUSY aborts the access; later ack is ignored
    issue(1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0);
    tick();
    req_valid_in = 1'b0;
    chk("rb_req", 32'(dmem_req_out), 32'h1);
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    chk("rb_req0",   32'(dmem_req_out), 32'h0);
    chk("rb_addr0",  dmem_addr_out, 32'h0);
    chk("rb_rdata0", rdata_out, 32'h0);
    chk("rb_stall0", 32'(stall_out), 32'h0);
    chk("rb_done0",  32'(done_out), 32'h0);
    dmem_ack_in = 1'b1;
    dmem_rdata_in = 32'h7777_7777;
    tick();
    dmem_ack_in = 1'b0;
    chk("rb_ack_ign_done", 32'(done_out), 32'h0);
    chk("rb_ack_ign_rdata", rdata_out, 32'h0);
    tick();
    chk("rb_ack_ign_done2", 32'(done_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
